// File: rtl/cpu_bus_mux_pipe_pkg.sv
// Shared select encodings, default source indices and skid-buffer count states
// for the cpu_bus_mux_pipe datapath mux.
package cpu_bus_mux_pipe_pkg;

    localparam int unsigned MUX_SEL_SRC_BASE = 0;

    localparam int unsigned REG_A = 0;
    localparam int unsigned REG_B = 1;
    localparam int unsigned ALU_Y = 2;
    localparam int unsigned PC    = 3;

    // Immediate and NONE codes sit directly above the full-width sources.
    function automatic int unsigned mux_sel_imm(input int unsigned num_src);
        return num_src;
    endfunction

    function automatic int unsigned mux_sel_none(input int unsigned num_src);
        return num_src + 1;
    endfunction

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/cpu_bus_mux_pipe_skid_buf.sv
// cpu_skid_buf: 2-entry valid/ready buffer; in_ready_o depends only on state,
// never combinationally on out_ready_i.
module cpu_skid_buf
    import cpu_bus_mux_pipe_pkg::*;
#(
    parameter int unsigned DW = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    cnt_state_e    state_q, state_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          push, pop;

    assign in_ready_o  = (state_q != CNT_FULL);
    assign out_valid_o = (state_q != CNT_EMPTY);
    assign out_data_o  = head_q;

    always_comb begin
        push    = in_valid_i && in_ready_o;
        pop     = out_valid_o && out_ready_i;
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            CNT_EMPTY: begin
                if (push) begin
                    head_d  = in_data_i;
                    state_d = CNT_ONE;
                end
            end
            CNT_ONE: begin
                // Accept with pop: new entry replaces the departing head.
                if (push && pop) begin
                    head_d = in_data_i;
                end else if (push) begin
                    tail_d  = in_data_i;
                    state_d = CNT_FULL;
                end else if (pop) begin
                    state_d = CNT_EMPTY;
                end
            end
            CNT_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = CNT_ONE;
                end
            end
            default: state_d = CNT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CNT_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/cpu_bus_mux_pipe.sv
// Datapath source mux feeding a 2-entry skid buffer. Define
// CPU_BUS_MUX_IMM_SIGN_EXT_EN to sign-extend the immediate instead of zero-extending.
module cpu_bus_mux_pipe
    import cpu_bus_mux_pipe_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IMM_W   = 5,
    parameter int unsigned SEL_W   = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_SRC*WIDTH-1:0] mux_src_i,
    input  logic [IMM_W-1:0]         mux_imm_i,
    input  logic [SEL_W-1:0]         mux_select_i,
    input  logic                     mux_valid_i,
    output logic                     mux_ready_o,
    output logic [WIDTH-1:0]         mux_data_o,
    output logic                     mux_valid_o,
    input  logic                     mux_ready_i,
    output logic                     mux_err_o
);

    logic [31:0]      sel_ext;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [WIDTH:0]   buf_out;

    assign sel_ext = 32'(mux_select_i);

`ifdef CPU_BUS_MUX_IMM_SIGN_EXT_EN
    assign imm_ext = WIDTH'($signed(mux_imm_i));
`else
    assign imm_ext = WIDTH'(mux_imm_i);
`endif

    always_comb begin
        sel_data = '0;
        sel_err  = 1'b0;
        if (sel_ext == mux_sel_imm(NUM_SRC)) begin
            sel_data = imm_ext;
        end else if (sel_ext == mux_sel_none(NUM_SRC)) begin
            sel_data = '0;
        end else if (sel_ext >= MUX_SEL_SRC_BASE + NUM_SRC) begin
            sel_err = 1'b1;
        end
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (sel_ext == MUX_SEL_SRC_BASE + k) begin
                sel_data = mux_src_i[k*WIDTH +: WIDTH];
            end
        end
    end

    cpu_skid_buf #(
        .DW (WIDTH + 1)
    ) u_skid_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (mux_valid_i),
        .in_ready_o  (mux_ready_o),
        .in_data_i   ({sel_data, sel_err}),
        .out_valid_o (mux_valid_o),
        .out_ready_i (mux_ready_i),
        .out_data_o  (buf_out)
    );

    assign mux_data_o = buf_out[WIDTH:1];
    assign mux_err_o  = buf_out[0];

endmodule

// File: tb/tb_cpu_bus_mux_pipe.sv
// Directed self-checking bench for cpu_bus_mux_pipe (default parameters).
module tb_cpu_bus_mux_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] src;
    logic [4:0]  imm;
    logic [2:0]  sel;
    logic        vin;
    logic        rdy_out;
    logic [7:0]  dout;
    logic        vout;
    logic        rdy_in;
    logic        err;

    int total = 0;
    int bad   = 0;

    cpu_bus_mux_pipe #(
        .WIDTH   (8),
        .NUM_SRC (4),
        .IMM_W   (5),
        .SEL_W   (3)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mux_src_i    (src),
        .mux_imm_i    (imm),
        .mux_select_i (sel),
        .mux_valid_i  (vin),
        .mux_ready_o  (rdy_out),
        .mux_data_o   (dout),
        .mux_valid_o  (vout),
        .mux_ready_i  (rdy_in),
        .mux_err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] stream_exp [5];
        logic [7:0] imm_exp;
        logic [7:0] pat_exp [4];
        stream_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        pat_exp    = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef CPU_BUS_MUX_IMM_SIGN_EXT_EN
        imm_exp = 8'hF6;
`else
        imm_exp = 8'h16;
`endif
        rst    = 1'b1;
        vin    = 1'b0;
        rdy_in = 1'b1;
        sel    = 3'd0;
        imm    = 5'd0;
        src    = {8'h44, 8'h33, 8'h22, 8'h11};
        #1;
        chk("rst_valid", 32'(vout), 32'd0);
        chk("rst_ready", 32'(rdy_out), 32'd1);
        chk("rst_data", 32'(dout), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        step();
        rst = 1'b0;

        // streaming: selects 0,1,2,3,NONE back to back
        vin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sel = 3'(i == 4 ? 5 : i);
            step();
            chk($sformatf("stream_data%0d", i), 32'(dout), 32'(stream_exp[i]));
            chk($sformatf("stream_valid%0d", i), 32'(vout), 32'd1);
            chk($sformatf("stream_err%0d", i), 32'(err), 32'd0);
        end
        vin = 1'b0;
        step();
        chk("stream_drain", 32'(vout), 32'd0);

        // backpressure, with sources changing after the entries are taken
        rdy_in = 1'b0;
        vin    = 1'b1;
        sel    = 3'd0;
        step();
        chk("bp_ready1", 32'(rdy_out), 32'd1);
        chk("bp_data1", 32'(dout), 32'h11);
        sel = 3'd1;
        step();
        chk("bp_ready_full", 32'(rdy_out), 32'd0);
        src = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        sel = 3'd2;
        step();
        chk("bp_ready_hold", 32'(rdy_out), 32'd0);
        chk("bp_data_hold", 32'(dout), 32'h11);
        rdy_in = 1'b1;
        step();
        chk("bp_pop2", 32'(dout), 32'h22);
        chk("bp_ready_back", 32'(rdy_out), 32'd1);
        step();
        chk("bp_third", 32'(dout), 32'hC3);
        vin = 1'b0;
        step();
        chk("bp_drain", 32'(vout), 32'd0);
        src = {8'h44, 8'h33, 8'h22, 8'h11};

        // immediate then illegal selects then legal
        vin = 1'b1;
        sel = 3'd4;
        imm = 5'b10110;
        step();
        chk("imm_data", 32'(dout), 32'(imm_exp));
        chk("imm_err", 32'(err), 32'd0);
        sel = 3'd6;
        step();
        chk("ill6_data", 32'(dout), 32'd0);
        chk("ill6_err", 32'(err), 32'd1);
        sel = 3'd7;
        step();
        chk("ill7_data", 32'(dout), 32'd0);
        chk("ill7_err", 32'(err), 32'd1);
        sel = 3'd1;
        step();
        chk("legal_data", 32'(dout), 32'h22);
        chk("legal_err", 32'(err), 32'd0);
        vin = 1'b0;
        step();
        chk("ill_drain", 32'(vout), 32'd0);

        // 10 transfers, no bubble
        vin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sel = 3'(i % 4);
            step();
            chk($sformatf("tp_valid%0d", i), 32'(vout), 32'd1);
            chk($sformatf("tp_data%0d", i), 32'(dout), 32'(pat_exp[i % 4]));
            chk($sformatf("tp_ready%0d", i), 32'(rdy_out), 32'd1);
        end
        vin = 1'b0;
        step();
        chk("tp_drain", 32'(vout), 32'd0);

        // asynchronous reset while FULL
        rdy_in = 1'b0;
        vin    = 1'b1;
        sel    = 3'd2;
        step();
        sel = 3'd3;
        step();
        chk("pre_rst_full", 32'(rdy_out), 32'd0);
        vin = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(vout), 32'd0);
        chk("arst_ready", 32'(rdy_out), 32'd1);
        chk("arst_data", 32'(dout), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        step();
        rst    = 1'b0;
        rdy_in = 1'b1;
        vin    = 1'b1;
        sel    = 3'd3;
        step();
        chk("post_rst_data", 32'(dout), 32'h44);
        vin = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
